sequential_multiply: RTL and testbench

Multi-cycle signed 16×16 → 32-bit multiplier for datapaths that can trade latency for area. A one-cycle `start` pulse loads the operands, and a radix-4 (modified Booth) iterative engine retires 2 multiplier bits per clock. The full two's-complement product is presented on a held output register, and `READY` flags idle/complete.

---
 rtl/sequential_multiply.sv | 107 ++++++++++
 tb/tb_sequential_multiply.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sequential_multiply.sv
// sequential_multiply: signed 16x16 -> 32 radix-4 Booth multiplier.
// One start pulse, eight iterations, result held until the next completion.
module sequential_multiply (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        start,
  output logic [31:0] product,
  output logic        READY
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  // Multiplicand, sign-extended so that +/-2A still fits.
  logic [17:0] r_mcand;
  // Upper partial-product bits; never exceeds 17 significant bits.
  logic [17:0] r_acc;
  // Multiplier bits still to retire, with the Booth guard bit at [0].
  logic [16:0] r_mplr;
  logic [2:0]  r_cnt;
  logic [31:0] r_product;

  logic        w_load;
  logic        w_step;
  logic        w_done;
  logic [17:0] w_mcand2;
  logic [17:0] w_term;
  logic [17:0] w_sum;
  logic [34:0] w_shift;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_BUSY);
  assign w_done = w_step && (r_cnt == 3'd7);

  assign w_mcand2 = {r_mcand[16:0], 1'b0};

  // Booth recoding of the current 3-bit multiplier window.
  always_comb begin
    w_term = 18'd0;
    unique case (r_mplr[2:0])
      3'b001,
      3'b010: w_term = r_mcand;
      3'b011: w_term = w_mcand2;
      3'b100: w_term = 18'd0 - w_mcand2;
      3'b101,
      3'b110: w_term = 18'd0 - r_mcand;
      default: w_term = 18'd0;
    endcase
  end

  assign w_sum = r_acc + w_term;

  // Accumulate then arithmetic-shift the acc/multiplier pair by two.
  assign w_shift = $signed({w_sum, r_mplr}) >>> 2;

  // Next-state logic for the idle/busy controller.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_BUSY;
      S_BUSY: if (r_cnt == 3'd7) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand load and Booth iteration datapath.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mcand <= 18'd0;
      r_acc   <= 18'd0;
      r_mplr  <= 17'd0;
      r_cnt   <= 3'd0;
    end else if (w_load) begin
      r_mcand <= {{2{A[15]}}, A};
      r_acc   <= 18'd0;
      r_mplr  <= {B, 1'b0};
      r_cnt   <= 3'd0;
    end else if (w_step) begin
      r_acc   <= w_shift[34:17];
      r_mplr  <= w_shift[16:0];
      r_cnt   <= r_cnt + 3'd1;
    end
  end

  // Result register, written only on the final iteration.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      r_product <= 32'd0;
    else if (w_done) r_product <= w_shift[32:1];
  end

  assign product = r_product;
  assign READY   = (r_state == S_IDLE);

endmodule

// File: tb/tb_sequential_multiply.sv
// tb_sequential_multiply: directed and random checks of the
// Booth multiplier against plain signed multiplication.
module tb_sequential_multiply;

  logic        CLK;
  logic        RESET;
  logic [15:0] A;
  logic [15:0] B;
  logic        start;
  logic [31:0] product;
  logic        READY;

  int n_chk;
  int n_err;

  sequential_multiply dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .A       (A),
    .B       (B),
    .start   (start),
    .product (product),
    .READY   (READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b);
    longint pa;
    longint pb;
    longint p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Start one op at a negedge, check 16 cycles after acceptance.
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (16) @(negedge CLK);
    chk(tag, product, ref_mul(a, b));
  endtask

  // Count cycles READY stays low after an accepted start.
  task automatic busy_len(output int n);
    n = 0;
    while (!READY && n < 20) begin
      n++;
      @(negedge CLK);
    end
  endtask

  int          n;
  logic [31:0] prev;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    n_chk = 0;
    n_err = 0;
    A = 16'd0;
    B = 16'd0;
    start = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_product", product, 32'd0);
    chk("rst_ready", {31'd0, READY}, 32'd1);
    RESET = 1'b1;

    // Directed values; first one starts on the edge right after reset.
    run_op("d_1x1",     16'd1,       16'd1);
    run_op("d_10x0",    16'd10,      16'd0);
    run_op("d_m10x0",   -16'sd10,    16'd0);
    run_op("d_0x10",    16'd0,       16'd10);
    run_op("d_0xm10",   16'd0,       -16'sd10);
    run_op("d_10x10",   16'd10,      16'd10);
    run_op("d_m10x10",  -16'sd10,    16'd10);
    run_op("d_10xm10",  16'd10,      -16'sd10);
    run_op("d_m10xm10", -16'sd10,    -16'sd10);
    chk("const_m10xm10", product, 32'd100);
    run_op("x_min_min", 16'h8000,    16'h8000);
    chk("const_min_min", product, 32'd1073741824);
    run_op("x_max_min", 16'h7fff,    16'h8000);
    chk("const_max_min", product, 32'hC0008000);
    run_op("x_max_max", 16'h7fff,    16'h7fff);
    chk("const_max_max", product, 32'd1073676289);
    run_op("x_m1_m1",   16'hffff,    16'hffff);

    // Handshake: busy length, ignored start, operand changes.
    prev = product;
    A = 16'd7;
    B = -16'sd3;
    start = 1'b1;
    @(negedge CLK);
    chk("hs_prod_hold", product, prev);
    A = 16'd5;
    B = 16'd5;
    @(negedge CLK);
    start = 1'b0;
    A = 16'h1234;
    B = 16'h8765;
    chk("hs_prod_hold2", product, prev);
    busy_len(n);
    chk("hs_busy_len", n, 32'd7);
    chk("hs_ready", {31'd0, READY}, 32'd1);
    chk("hs_result", product, 32'hFFFFFFEB);
    repeat (3) @(negedge CLK);
    chk("hs_result_held", product, 32'hFFFFFFEB);

    // Exact busy length, and a start raised at E8 is ignored.
    A = 16'd300;
    B = -16'sd7;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    A = 16'd9;
    B = 16'd9;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("e8_ready", {31'd0, READY}, 32'd1);
    chk("e8_result", product, ref_mul(16'd300, -16'sd7));

    // Back-to-back: start on E9 is accepted.
    A = 16'd11;
    B = 16'd13;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("b2b_busy", {31'd0, READY}, 32'd0);
    busy_len(n);
    chk("b2b_len", n, 32'd8);
    chk("b2b_result", product, 32'd143);

    // Asynchronous reset between edges.
    #2;
    RESET = 1'b0;
    #1;
    chk("async_product", product, 32'd0);
    chk("async_ready", {31'd0, READY}, 32'd1);
    @(negedge CLK);
    RESET = 1'b1;

    // Reset mid-operation discards the in-flight op.
    A = 16'd100;
    B = 16'd200;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("mid_rst_product", product, 32'd0);
    chk("mid_rst_ready", {31'd0, READY}, 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (10) @(negedge CLK);
    chk("mid_rst_discard", product, 32'd0);
    run_op("mid_rst_3x4", 16'd3, 16'd4);
    chk("const_3x4", product, 32'd12);

    // Random regression, one start every 17 cycles.
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      if ($urandom_range(0, 15) == 0) ra = 16'h8000;
      if ($urandom_range(0, 15) == 0) rb = 16'h8000;
      run_op("rand", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
